// File: rtl/rc4_stream_decipher.sv
// rc4_stream_decipher
// Receive-side RC4 stage: buffers keystream bytes from key_gene in a small FIFO
// and XORs them onto the incoming ciphertext to recover plaintext. All byte
// interfaces are valid/ready. Defining RC4_DROP_EN builds the RC4-drop[DROP_N]
// prefix discard (DROP state + counter); without it start goes straight to RUN.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; keystream FIFO contents kept, no refill
// DROP   | discarding the first DROP_N keystream bytes (RC4_DROP_EN only)
// RUN    | buffering keystream, deciphering ciphertext into the output reg
// DONE   | one-cycle done pulse, then back to IDLE
module rc4_stream_decipher #(
  parameter int KS_DEPTH = 4,
  parameter int LEN_W    = 16
`ifdef RC4_DROP_EN
  ,
  parameter int DROP_N   = 256
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             abort,
  input  logic             ks_valid,
  input  logic [7:0]       ks_data,
  output logic             ks_ready,
  input  logic             ct_valid,
  input  logic [7:0]       ct_data,
  output logic             ct_ready,
  output logic             pt_valid,
  output logic [7:0]       pt_data,
  input  logic             pt_ready,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] remain
);

  localparam int PTR_W = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
`ifdef RC4_DROP_EN
    ,
    S_DROP = 2'd3
`endif
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       fifo_mem [KS_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             ks_hs;
  logic             ct_hs;
  logic             push;
  logic             pop;

  assign fifo_full  = (fifo_cnt == CNT_W'(KS_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign ks_hs      = ks_valid && ks_ready;
  assign ct_hs      = ct_valid && ct_ready;
  // Only RUN stores keystream; DROP handshakes are discarded.
  assign push       = ks_hs && (state == S_RUN);
  assign pop        = ct_hs;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

`ifdef RC4_DROP_EN
  localparam int DROP_W = (DROP_N > 1) ? $clog2(DROP_N) : 1;

  logic [DROP_W-1:0] drop_cnt;
  logic              dropped;
  logic              drop_last;
  logic              drop_pending;

  assign drop_last    = (drop_cnt == DROP_W'(DROP_N - 1));
  assign drop_pending = !dropped && (DROP_N != 0);

  // Count discarded prefix bytes; dropped persists until reset or a mid-message abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
      dropped  <= 1'b0;
    end else if (abort && (state != S_IDLE)) begin
      drop_cnt <= '0;
      dropped  <= 1'b0;
    end else if ((state == S_DROP) && ks_hs) begin
      if (drop_last) begin
        drop_cnt <= '0;
        dropped  <= 1'b1;
      end else begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end
`endif

  // Handshake readies are combinational from state and FIFO occupancy.
  always_comb begin
    ks_ready = 1'b0;
    ct_ready = 1'b0;
    if (state == S_RUN) begin
      ks_ready = !fifo_full;
      ct_ready = (remain != '0) && !fifo_empty && (!pt_valid || pt_ready);
    end
`ifdef RC4_DROP_EN
    if (state == S_DROP) ks_ready = 1'b1;
`endif
  end

  // Next-state logic; abort overrides everything, including a same-cycle start.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (msg_len == '0) state_nxt = S_DONE;
`ifdef RC4_DROP_EN
          else if (drop_pending) state_nxt = S_DROP;
`endif
          else state_nxt = S_RUN;
        end
      end
`ifdef RC4_DROP_EN
      S_DROP: begin
        if (ks_hs && drop_last) state_nxt = S_RUN;
      end
`endif
      S_RUN: begin
        if ((remain == '0) && (!pt_valid || pt_ready)) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Keystream FIFO pointers and occupancy; abort in any state flushes it.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Keystream storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ks_data;
  end

  // Remaining-byte counter and the plaintext output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      remain   <= '0;
      pt_valid <= 1'b0;
      pt_data  <= 8'h00;
    end else if (abort) begin
      remain   <= '0;
      pt_valid <= 1'b0;
    end else begin
      if ((state == S_IDLE) && start) remain <= msg_len;
      else if (ct_hs)                 remain <= remain - LEN_W'(1);
      if (ct_hs) begin
        pt_data  <= ct_data ^ fifo_mem[rd_ptr];
        pt_valid <= 1'b1;
      end else if (pt_ready) begin
        pt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rc4_stream_decipher.sv
// Testbench for rc4_stream_decipher: table of message vectors plus hand-written
// stall / zero-length / abort / reset sequences. Expected plaintext bytes are
// queued when a ciphertext handshake is seen and popped when the DUT emits.
// The drop-prefix sequence runs only when RC4_DROP_EN is defined.
module tb_rc4_stream_decipher;
  localparam int LEN_W = 16;
  localparam int TMO   = 200;

  typedef logic [7:0] bq_t [$];
  typedef struct {
    int         len;
    logic [7:0] ks [4];
    logic [7:0] ct [4];
    logic [7:0] pt [4];
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] msg_len;
  logic             abort;
  logic             ks_valid;
  logic [7:0]       ks_data;
  logic             ks_ready;
  logic             ct_valid;
  logic [7:0]       ct_data;
  logic             ct_ready;
  logic             pt_valid;
  logic [7:0]       pt_data;
  logic             pt_ready;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] remain;

  int         n_checks = 0;
  int         n_errors = 0;
  int         done_cnt = 0;
  logic       ct_hs_prev = 1'b0;
  logic       done_prev = 1'b0;
  logic [7:0] exp_q [$];
  vec_t       vecs [4];

  always #5 clk = ~clk;

  rc4_stream_decipher #(
    .KS_DEPTH(4),
    .LEN_W(LEN_W)
`ifdef RC4_DROP_EN
    ,
    .DROP_N(4)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start), .msg_len(msg_len), .abort(abort),
    .ks_valid(ks_valid), .ks_data(ks_data), .ks_ready(ks_ready),
    .ct_valid(ct_valid), .ct_data(ct_data), .ct_ready(ct_ready),
    .pt_valid(pt_valid), .pt_data(pt_data), .pt_ready(pt_ready),
    .busy(busy), .done(done), .remain(remain)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: no handshake within %0d cycles, expected one", name, TMO);
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: latency, single-cycle done, and scoreboard compare.
  always @(negedge clk) begin
    if (ct_hs_prev) chk("pt_latency", 32'(pt_valid), 32'd1);
    if (done_prev)  chk("done_one_cycle", 32'(done), 32'd0);
    if (pt_valid && pt_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL pt_unexpected: got 0x%0h, expected no output", pt_data);
      end else begin
        chk("pt_data", 32'(pt_data), 32'(exp_q.pop_front()));
      end
    end
    ct_hs_prev = ct_valid && ct_ready && !rst && !abort;
    done_prev  = done;
    if (done) done_cnt++;
  end

  task automatic drive_ks(input bq_t bq);
    int t;
    foreach (bq[i]) begin
      ks_valid = 1'b1;
      ks_data  = bq[i];
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!ks_ready && t < TMO);
      if (!ks_ready) timeout_fail("ks_handshake");
      tick();
    end
    ks_valid = 1'b0;
  endtask

  task automatic drive_ct(input bq_t cq, input bq_t pq);
    int t;
    foreach (cq[i]) begin
      ct_valid = 1'b1;
      ct_data  = cq[i];
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!ct_ready && t < TMO);
      if (ct_ready) exp_q.push_back(pq[i]);
      else          timeout_fail("ct_handshake");
      tick();
    end
    ct_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done && t < TMO);
    chk("done_pulse", 32'(done), 32'd1);
    tick();
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'd0);
    tick();
  endtask

  task automatic run_msg(input int len, input bq_t kq, input bq_t cq, input bq_t pq);
    start   = 1'b1;
    msg_len = LEN_W'(len);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("remain_latched", 32'(remain), 32'(len));
    chk("busy_running", 32'(busy), 32'd1);
    tick();
    fork
      drive_ks(kq);
      drive_ct(cq, pq);
    join
    wait_done();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // A fresh drop window after reset/abort needs DROP_N filler bytes in front.
  function automatic bq_t with_drop(input bq_t q);
    bq_t r;
    r = q;
`ifdef RC4_DROP_EN
    for (int i = 0; i < 4; i++) r.push_front(8'hEE);
`endif
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bq_t kq, cq, pq;
    int  d0;

    vecs[0] = '{3, '{8'h11, 8'h22, 8'h33, 8'h00}, '{8'hAA, 8'hBB, 8'hCC, 8'h00}, '{8'hBB, 8'h99, 8'hFF, 8'h00}};
    vecs[1] = '{4, '{8'h01, 8'h02, 8'h04, 8'h08}, '{8'hFF, 8'hFF, 8'hFF, 8'hFF}, '{8'hFE, 8'hFD, 8'hFB, 8'hF7}};
    vecs[2] = '{1, '{8'h5A, 8'h00, 8'h00, 8'h00}, '{8'hA5, 8'h00, 8'h00, 8'h00}, '{8'hFF, 8'h00, 8'h00, 8'h00}};
    vecs[3] = '{2, '{8'h00, 8'hFF, 8'h00, 8'h00}, '{8'h3C, 8'h3C, 8'h00, 8'h00}, '{8'h3C, 8'hC3, 8'h00, 8'h00}};

    rst = 1'b1; start = 1'b0; msg_len = '0; abort = 1'b0;
    ks_valid = 1'b0; ks_data = 8'h00; ct_valid = 1'b0; ct_data = 8'h00; pt_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_pt_valid", 32'(pt_valid), 32'd0);
    chk("rst_pt_data", 32'(pt_data), 32'd0);
    chk("rst_ks_ready", 32'(ks_ready), 32'd0);
    chk("rst_ct_ready", 32'(ct_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_remain", 32'(remain), 32'd0);
    tick();
    rst = 1'b0;
    tick();

`ifdef RC4_DROP_EN
    // Drop window of 4: bytes 01..04 discarded, 05/06 used; next message must not drop.
    kq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    cq = {8'h00, 8'h00};
    pq = {8'h05, 8'h06};
    run_msg(2, kq, cq, pq);
    kq = {8'h07};
    cq = {8'h00};
    pq = {8'h07};
    run_msg(1, kq, cq, pq);
`endif

    foreach (vecs[v]) begin
      kq.delete(); cq.delete(); pq.delete();
      for (int j = 0; j < vecs[v].len; j++) begin
        kq.push_back(vecs[v].ks[j]);
        cq.push_back(vecs[v].ct[j]);
        pq.push_back(vecs[v].pt[j]);
      end
      run_msg(vecs[v].len, kq, cq, pq);
    end

    // Output stall: pt held stable, ct blocked, FIFO fills until ks_ready drops.
    pt_ready = 1'b0;
    start    = 1'b1;
    msg_len  = LEN_W'(2);
    tick();
    start = 1'b0;
    kq = {8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    cq = {8'h10};
    pq = {8'hB1};
    fork
      drive_ks(kq);
    join_none
    drive_ct(cq, pq);
    ct_valid = 1'b1;
    ct_data  = 8'h20;
    repeat (5) begin
      @(negedge clk);
      chk("stall_pt_valid", 32'(pt_valid), 32'd1);
      chk("stall_pt_data", 32'(pt_data), 32'hB1);
      chk("stall_ct_ready", 32'(ct_ready), 32'd0);
      tick();
    end
    @(negedge clk);
    chk("stall_fifo_full", 32'(ks_ready), 32'd0);
    tick();
    pt_ready = 1'b1;
    cq = {8'h20};
    pq = {8'h92};
    drive_ct(cq, pq);
    wait fork;
    wait_done();
    chk("stall_drained", 32'(exp_q.size()), 32'd0);

    // Leftover keystream C3,D4,E5 carries into the next message.
    kq.delete();
    cq = {8'h00, 8'h00, 8'h00};
    pq = {8'hC3, 8'hD4, 8'hE5};
    run_msg(3, kq, cq, pq);

    // Zero-length message: done next cycle, no keystream taken.
    ks_valid = 1'b1;
    ks_data  = 8'h5A;
    d0       = done_cnt;
    start    = 1'b1;
    msg_len  = '0;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd1);
    chk("len0_ks_ready", 32'(ks_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("len0_busy_after", 32'(busy), 32'd0);
    chk("len0_ks_ready_idle", 32'(ks_ready), 32'd0);
    tick();
    ks_valid = 1'b0;
    chk("len0_done_count", 32'(done_cnt - d0), 32'd1);

    // Abort after 2 of 5 bytes with the second plaintext byte still held.
    start   = 1'b1;
    msg_len = LEN_W'(5);
    tick();
    start = 1'b0;
    kq = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    cq = {8'hF0, 8'h0F};
    pq = {8'hC1, 8'h3D};
    fork
      drive_ks(kq);
    join_none
    drive_ct(cq, pq);
    pt_ready = 1'b0;
    wait fork;
    d0    = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_pt_valid", 32'(pt_valid), 32'd0);
    chk("abort_remain", 32'(remain), 32'd0);
    chk("abort_ct_ready", 32'(ct_ready), 32'd0);
    tick();
    pt_ready = 1'b1;
    tick();
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    // Flushed FIFO: the new byte 77 must be the first one used.
    kq = {8'h77};
    kq = with_drop(kq);
    cq = {8'h00};
    pq = {8'h77};
    run_msg(1, kq, cq, pq);

    // Reset mid-RUN, then a normal message.
    start   = 1'b1;
    msg_len = LEN_W'(3);
    tick();
    start = 1'b0;
    kq = {8'h41, 8'h42, 8'h43};
    cq = {8'h01};
    pq = {8'h40};
    fork
      drive_ks(kq);
    join_none
    drive_ct(cq, pq);
    wait fork;
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("mid_rst_pt_valid", 32'(pt_valid), 32'd0);
    chk("mid_rst_pt_data", 32'(pt_data), 32'd0);
    chk("mid_rst_ks_ready", 32'(ks_ready), 32'd0);
    chk("mid_rst_ct_ready", 32'(ct_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_remain", 32'(remain), 32'd0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    tick();
    kq = {8'h12, 8'h34};
    kq = with_drop(kq);
    cq = {8'h00, 8'h00};
    pq = {8'h12, 8'h34};
    run_msg(2, kq, cq, pq);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
